objects_compositor: RTL and testbench

//  Consumer end of the bitmap-drawer interface: collects {drawingRequest, RGBout} from all title,

---
 rtl/objects_pkg.sv | 16 +
 rtl/collision_pair_tracker.sv | 28 ++
 rtl/objects_compositor.sv | 49 ++++
 tb/tb_objects_compositor.sv | 130 +++++++++++++
 4 files changed

// File: rtl/objects_pkg.sv
// objects_pkg: layer count, layer roles, pair indexing and pair FSM states shared by the compositor
package objects_pkg;
  localparam int NUM_LAYERS_DEF = 8;
  localparam int LYR_PLAYER  = 0;
  localparam int LYR_MISSILE = 1;
  localparam int LYR_ALIENS  = 2;
  localparam int LYR_HUD     = 6;
  localparam int LYR_TITLES  = 7;
  typedef enum logic {CLEAR, SEEN} pair_state_t;
  function automatic int npairs(input int n);
    return n * (n - 1) / 2;
  endfunction
  function automatic int pair_index(input int i, input int j, input int n);
    return i * n - i * (i + 1) / 2 + (j - i - 1);
  endfunction
endpackage

// File: rtl/collision_pair_tracker.sv
// collision_pair_tracker: per-frame sticky overlap flag, first-overlap pulse and previous-frame snapshot for one layer pair
module collision_pair_tracker
  import objects_pkg::*;
(
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic overlap,
  output logic pulse,
  output logic frame_flag
);
  pair_state_t state, state_next;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= CLEAR;
      pulse      <= 1'b0;
      frame_flag <= 1'b0;
    end else begin
      state <= state_next;
      // the startOfFrame pixel opens a new frame, so an overlap there always pulses
      pulse <= overlap & (startOfFrame | (state == CLEAR));
      if (startOfFrame) frame_flag <= (state == SEEN);
    end
  end
  always_comb begin
    state_next = (overlap | ((state == SEEN) & ~startOfFrame)) ? SEEN : CLEAR;
  end
endmodule

// File: rtl/objects_compositor.sv
// objects_compositor: priority-composites drawer layers into one RGB pixel and reports per-frame layer-pair collisions
module objects_compositor
  import objects_pkg::*;
#(
  parameter int          NUM_LAYERS = NUM_LAYERS_DEF,
  parameter logic [7:0]  BG_RGB     = 8'h00,
  parameter logic [7:0]  IDLE_RGB   = 8'h00,
  localparam int         NPAIRS     = npairs(NUM_LAYERS)
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    playGame,
  input  logic [NUM_LAYERS-1:0]   layerReq,
  input  logic [NUM_LAYERS*8-1:0] layerRGB,
  output logic [7:0]              RGBOut,
  output logic                    anyDraw,
  output logic [NPAIRS-1:0]       collisionPulse,
  output logic [NPAIRS-1:0]       collisionFrame
);
  logic [7:0] sel;
  always_comb begin
    sel = BG_RGB;
    for (int k = NUM_LAYERS - 1; k >= 0; k--)
      if (layerReq[k]) sel = layerRGB[8*k +: 8];
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGBOut  <= IDLE_RGB;
      anyDraw <= 1'b0;
    end else begin
      RGBOut  <= playGame ? sel : IDLE_RGB;
      anyDraw <= playGame & |layerReq;
    end
  end
  for (genvar i = 0; i < NUM_LAYERS - 1; i++) begin : g_i
    for (genvar j = i + 1; j < NUM_LAYERS; j++) begin : g_j
      localparam int P = pair_index(i, j, NUM_LAYERS);
      collision_pair_tracker u_pair (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .overlap      (playGame & layerReq[i] & layerReq[j]),
        .pulse        (collisionPulse[P]),
        .frame_flag   (collisionFrame[P])
      );
    end
  end
endmodule

// File: tb/tb_objects_compositor.sv
// tb_objects_compositor: directed and randomized checks of compositing and collision reporting against a frame-level model
module tb_objects_compositor;
  localparam int N  = 8;
  localparam int NP = N * (N - 1) / 2;
  logic          clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0, playGame = 1'b0;
  logic [N-1:0]  layerReq = '0;
  logic [N*8-1:0] layerRGB = '0;
  logic [7:0]    RGBOut;
  logic          anyDraw;
  logic [NP-1:0] collisionPulse, collisionFrame;
  logic [7:0]    m_rgb;
  logic          m_any;
  logic [NP-1:0] m_seen, m_pulse, m_frame;
  int checks = 0, errors = 0;

  objects_compositor dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .playGame(playGame),
    .layerReq(layerReq), .layerRGB(layerRGB), .RGBOut(RGBOut), .anyDraw(anyDraw),
    .collisionPulse(collisionPulse), .collisionFrame(collisionFrame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rgb"},   32'(RGBOut),         32'(m_rgb));
    chk({tag, ".any"},   32'(anyDraw),        32'(m_any));
    chk({tag, ".pulse"}, 32'(collisionPulse), 32'(m_pulse));
    chk({tag, ".frame"}, 32'(collisionFrame), 32'(m_frame));
  endtask

  task automatic model_reset();
    m_rgb = 8'h00; m_any = 1'b0; m_seen = '0; m_pulse = '0; m_frame = '0;
  endtask

  // one pixel of the frame: topmost requesting layer wins; each pair reports its first overlap per frame
  task automatic model_step();
    int p;
    logic ov;
    m_rgb = 8'h00;
    if (playGame) for (int k = 0; k < N; k++) if (layerReq[k]) begin m_rgb = layerRGB[8*k +: 8]; break; end
    m_any = playGame && (layerReq != 0);
    p = 0;
    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++) begin
        ov = playGame && layerReq[a] && layerReq[b];
        if (startOfFrame) begin
          m_pulse[p] = ov;
          m_frame[p] = m_seen[p];
          m_seen[p]  = ov;
        end else begin
          m_pulse[p] = ov && !m_seen[p];
          m_seen[p]  = m_seen[p] || ov;
        end
        p++;
      end
  endtask

  task automatic step(input logic sof, input logic pg, input logic [N-1:0] req, input logic [N*8-1:0] rgb, input string tag);
    startOfFrame = sof; playGame = pg; layerReq = req; layerRGB = rgb;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  logic [N*8-1:0] rgb_a, rgb_3f;
  int pulses;

  initial begin
    model_reset();
    rgb_a  = {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h1C, 8'hE0, 8'h11};
    rgb_3f = {N{8'h3F}};
    playGame = 1'b1; layerReq = 8'hFF; layerRGB = rgb_a;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    #3 resetN = 1'b1;
    step(0, 1, 8'b0000_0110, rgb_a, "prio");
    chk("prio.e0", 32'(RGBOut), 32'h E0);
    chk("prio.any1", 32'(anyDraw), 32'h1);
    step(0, 1, 8'h00, rgb_a, "bg");
    chk("bg.rgb0", 32'(RGBOut), 32'h00);
    step(1, 1, 8'h00, rgb_a, "sof1");
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      step(0, 1, 8'h03, rgb_a, "ov01");
      pulses += int'(collisionPulse[0]);
    end
    chk("ov01.one_pulse", 32'(pulses), 32'd1);
    step(1, 1, 8'h00, rgb_a, "sof2");
    chk("sof2.frame01", 32'(collisionFrame), 32'h1);
    step(1, 1, 8'b0010_0100, rgb_a, "sof_ov25");
    chk("sof_ov25.pulse", 32'(collisionPulse), 32'(1 << 15));
    chk("sof_ov25.frame", 32'(collisionFrame[15]), 32'h0);
    step(0, 1, 8'b0010_0100, rgb_a, "ov25_again");
    chk("ov25_again.nopulse", 32'(collisionPulse), 32'h0);
    step(1, 1, 8'h00, rgb_a, "sof4");
    chk("sof4.frame25", 32'(collisionFrame), 32'(1 << 15));
    step(0, 0, 8'hFF, rgb_3f, "idle");
    chk("idle.rgb", 32'(RGBOut), 32'h00);
    chk("idle.pulse", 32'(collisionPulse), 32'h0);
    step(0, 0, 8'hFF, rgb_3f, "idle2");
    step(0, 1, 8'h81, rgb_a, "ov07");
    chk("ov07.pulse", 32'(collisionPulse), 32'(1 << 6));
    #2 resetN = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #1 resetN = 1'b1;
    step(0, 1, 8'h00, rgb_a, "post_rst");
    step(1, 1, 8'h00, rgb_a, "post_rst_sof");
    chk("post_rst_sof.frame", 32'(collisionFrame), 32'h0);
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] r;
      r = N'($urandom) & N'($urandom) & N'($urandom);
      step($urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0, r,
           {$urandom, $urandom}, "rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
